usb_device_txn: RTL and testbench



---
 rtl/usb_pkg.sv | 28 ++
 rtl/usb_timeout.sv | 23 ++
 rtl/usb_device_txn.sv | 140 ++++++++++++++
 tb/tb_usb_device_txn.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: PID and FSM state encodings plus default endpoint/address constants shared by device and host
package usb_pkg;

   typedef enum logic [3:0] {
      PID_OUT   = 4'b0001,
      PID_IN    = 4'b1001,
      PID_DATA0 = 4'b0011,
      PID_ACK   = 4'b0010,
      PID_NAK   = 4'b1010
   } pid_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ADDR,
      S_WAIT_WDATA,
      S_MEM_WR,
      S_MEM_RD,
      S_SEND_DATA,
      S_WAIT_HS,
      S_SEND_HS
   } state_e;

   localparam logic [6:0] DEV_ADDR_DEF  = 7'd5;
   localparam logic [3:0] ADDR_ENDP_DEF = 4'd4;
   localparam logic [3:0] DATA_ENDP_DEF = 4'd8;
   localparam logic [7:0] TIMEOUT_DEF   = 8'd255;

endpackage

// File: rtl/usb_timeout.sv
// usb_timeout: 8-bit clearable counter that saturates at LIMIT and flags expiry
module usb_timeout #(
   parameter logic [7:0] LIMIT = 8'd255
) (
   input  logic clk,
   input  logic rst_L,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [7:0] cnt_q;

   assign expired_o = (cnt_q == LIMIT);

   // count enabled cycles since the last clear, holding once the limit is reached
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) cnt_q <= '0;
      else if (clr_i) cnt_q <= '0;
      else if (en_i && !expired_o) cnt_q <= cnt_q + 8'd1;
   end

endmodule

// File: rtl/usb_device_txn.sv
// usb_device_txn: USB device transaction engine bridging address/data endpoints to a 64-bit memory port
module usb_device_txn
   import usb_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEF,
   parameter logic [3:0] ADDR_ENDP = ADDR_ENDP_DEF,
   parameter logic [3:0] DATA_ENDP = DATA_ENDP_DEF,
   parameter logic [7:0] TIMEOUT   = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst_L,
   input  logic        rx_valid,
   input  logic [3:0]  rx_pid,
   input  logic [6:0]  rx_addr,
   input  logic [3:0]  rx_endp,
   input  logic [63:0] rx_data,
   input  logic        rx_crc_ok,
   input  logic        tx_ready,
   output logic        tx_start,
   output logic [3:0]  tx_pid,
   output logic [63:0] tx_data,
   output logic        mem_re,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [3:0]  tx_pid_q, tx_pid_d;
   logic [63:0] tx_data_q, tx_data_d;
   logic        rd_pend_q, rd_pend_d;
   logic        tok_ok, data_rx, hs_rx, expired, to_clr, to_en;

   // tokens must pass CRC5 and target this device; data/handshake packets carry no address
   assign tok_ok  = rx_valid && rx_crc_ok && (rx_addr == DEV_ADDR);
   assign data_rx = rx_valid && (rx_pid == PID_DATA0);
   assign hs_rx   = rx_valid && (rx_pid == PID_ACK || rx_pid == PID_NAK);
   assign to_clr  = rx_valid || (state_d != state_q);
   assign to_en   = state_q inside {S_WAIT_ADDR, S_WAIT_WDATA, S_WAIT_HS};

   usb_timeout #(.LIMIT(TIMEOUT)) u_timeout (
      .clk       (clk),
      .rst_L     (rst_L),
      .clr_i     (to_clr),
      .en_i      (to_en),
      .expired_o (expired)
   );

   assign tx_pid    = tx_pid_q;
   assign tx_data   = tx_data_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state_q != S_IDLE);

   // state and datapath registers; the outgoing PID/data are loaded before tx_start so they stay stable
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         tx_pid_q  <= '0;
         tx_data_q <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tx_pid_q  <= tx_pid_d;
         tx_data_q <= tx_data_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   // next-state, packet queueing and strobe generation
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      tx_pid_d  = tx_pid_q;
      tx_data_d = tx_data_q;
      rd_pend_d = 1'b0;
      tx_start  = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tok_ok && rx_pid == PID_OUT && rx_endp == ADDR_ENDP) state_d = S_WAIT_ADDR;
            else if (tok_ok && rx_pid == PID_OUT && rx_endp == DATA_ENDP) state_d = S_WAIT_WDATA;
            else if (tok_ok && rx_pid == PID_IN && rx_endp == DATA_ENDP) state_d = S_MEM_RD;
         end
         S_WAIT_ADDR: begin
            if (data_rx) begin
               state_d  = S_SEND_HS;
               tx_pid_d = rx_crc_ok ? PID_ACK : PID_NAK;
               addr_d   = rx_crc_ok ? rx_data[15:0] : addr_q;
            end else if (expired) state_d = S_IDLE;
         end
         S_WAIT_WDATA: begin
            if (data_rx && rx_crc_ok) begin
               state_d = S_MEM_WR;
               wdata_d = rx_data;
            end else if (data_rx) begin
               state_d  = S_SEND_HS;
               tx_pid_d = PID_NAK;
            end else if (expired) state_d = S_IDLE;
         end
         S_MEM_WR: begin
            mem_we   = 1'b1;
            tx_pid_d = PID_ACK;
            state_d  = S_SEND_HS;
         end
         S_MEM_RD: begin
            mem_re    = !rd_pend_q;
            rd_pend_d = !rd_pend_q;
            if (rd_pend_q) begin
               tx_data_d = mem_rdata;
               tx_pid_d  = PID_DATA0;
               state_d   = S_SEND_DATA;
            end
         end
         S_SEND_DATA: begin
            tx_start = tx_ready;
            state_d  = tx_ready ? S_WAIT_HS : S_SEND_DATA;
         end
         S_WAIT_HS: begin
            if (hs_rx || expired) state_d = S_IDLE;
         end
         S_SEND_HS: begin
            tx_start = tx_ready;
            state_d  = tx_ready ? S_IDLE : S_SEND_HS;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_usb_device_txn.sv
// tb_usb_device_txn: randomized host-side transactions checked against a transaction-level memory/address model
module tb_usb_device_txn;
   import usb_pkg::*;

   localparam logic [6:0] DEV = 7'd5;

   logic        clk = 1'b0;
   logic        rst_L = 1'b0;
   logic        rx_valid = 1'b0;
   logic [3:0]  rx_pid = '0;
   logic [6:0]  rx_addr = '0;
   logic [3:0]  rx_endp = '0;
   logic [63:0] rx_data = '0;
   logic        rx_crc_ok = 1'b0;
   logic        tx_ready = 1'b0;
   logic        tx_start, mem_re, mem_we, busy;
   logic [3:0]  tx_pid;
   logic [63:0] tx_data, mem_wdata;
   logic [15:0] mem_addr;
   logic [63:0] mem_rdata = '0;

   usb_device_txn dut (
      .clk       (clk),
      .rst_L     (rst_L),
      .rx_valid  (rx_valid),
      .rx_pid    (rx_pid),
      .rx_addr   (rx_addr),
      .rx_endp   (rx_endp),
      .rx_data   (rx_data),
      .rx_crc_ok (rx_crc_ok),
      .tx_ready  (tx_ready),
      .tx_start  (tx_start),
      .tx_pid    (tx_pid),
      .tx_data   (tx_data),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // environment: memory behind the device and a transmitter that is randomly busy
   logic [63:0] mem [logic [15:0]];
   always @(posedge clk) begin
      tx_ready <= ($urandom_range(0, 3) != 0);
      if (mem_we) mem[mem_addr] = mem_wdata;
      if (mem_re) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 64'd0;
   end

   // monitor: log every transmitted packet and memory strobe
   logic [67:0] tx_log [0:1023];
   int tx_cnt = 0, nr = 0, nw = 0, n_excl = 0;
   logic [15:0] w_addr = '0;
   logic [63:0] w_data = '0;
   always @(negedge clk) begin
      if (tx_start) begin
         tx_log[tx_cnt] = {tx_pid, tx_data};
         tx_cnt++;
      end
      if (mem_re) nr++;
      if (mem_we) begin
         nw++;
         w_addr = mem_addr;
         w_data = mem_wdata;
      end
      if (tx_start && (mem_re || mem_we)) n_excl++;
   end

   // transaction-level reference model
   logic [15:0] ref_addr = '0;
   logic [63:0] ref_mem [logic [15:0]];

   function automatic logic [63:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 64'd0;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] ep,
                       input logic [63:0] d, input logic ok);
      rx_pid = pid; rx_addr = a; rx_endp = ep; rx_data = d; rx_crc_ok = ok; rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 600) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic wait_tx(input int base, input string tag);
      int n = 0;
      while (tx_cnt == base && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_txseen"}, 64'(tx_cnt > base), 64'd1);
   endtask

   task automatic do_addr(input logic [15:0] v, input logic ok);
      int b_tx = tx_cnt, b_w = nw, b_r = nr;
      send(PID_OUT, DEV, 4'd4, rnd64(), 1'b1);
      tick($urandom_range(0, 3));
      send(PID_DATA0, 7'($urandom), 4'($urandom), {rnd64() >> 16, v}, ok);
      wait_idle("addr");
      tick(2);
      check("addr_ntx", 64'(tx_cnt - b_tx), 64'd1);
      check("addr_pid", 64'(tx_log[b_tx][67:64]), ok ? 64'(PID_ACK) : 64'(PID_NAK));
      check("addr_nmem", 64'((nw - b_w) + (nr - b_r)), 64'd0);
      if (ok) ref_addr = v;
   endtask

   task automatic do_write(input logic [63:0] d, input logic ok);
      int b_tx = tx_cnt, b_w = nw, b_r = nr;
      send(PID_OUT, DEV, 4'd8, rnd64(), 1'b1);
      tick($urandom_range(0, 3));
      send(PID_DATA0, 7'($urandom), 4'($urandom), d, ok);
      wait_idle("wr");
      tick(2);
      check("wr_nw", 64'(nw - b_w), ok ? 64'd1 : 64'd0);
      check("wr_nr", 64'(nr - b_r), 64'd0);
      if (ok) begin
         check("wr_addr", 64'(w_addr), 64'(ref_addr));
         check("wr_data", w_data, d);
         ref_mem[ref_addr] = d;
      end
      check("wr_ntx", 64'(tx_cnt - b_tx), 64'd1);
      check("wr_pid", 64'(tx_log[b_tx][67:64]), ok ? 64'(PID_ACK) : 64'(PID_NAK));
   endtask

   // hs: 0 = host ACKs, 1 = host NAKs, 2 = host stays silent (handshake timeout)
   task automatic do_read(input int hs);
      int b_tx = tx_cnt, b_w = nw, b_r = nr;
      logic [63:0] exp = ref_rd(ref_addr);
      send(PID_IN, DEV, 4'd8, rnd64(), 1'b1);
      wait_tx(b_tx, "rd");
      check("rd_pid", 64'(tx_log[b_tx][67:64]), 64'(PID_DATA0));
      check("rd_data", tx_log[b_tx][63:0], exp);
      check("rd_nr", 64'(nr - b_r), 64'd1);
      if (hs < 2) begin
         tick($urandom_range(1, 3));
         send(hs == 0 ? PID_ACK : PID_NAK, 7'($urandom), 4'($urandom), rnd64(), 1'b1);
      end
      wait_idle("rd");
      tick(2);
      check("rd_ntx", 64'(tx_cnt - b_tx), 64'd1);
      check("rd_nw", 64'(nw - b_w), 64'd0);
      check("rd_nr_total", 64'(nr - b_r), 64'd1);
   endtask

   task automatic do_filter(input int k);
      int b_tx = tx_cnt, b_w = nw, b_r = nr;
      logic [6:0] a = DEV;
      logic [3:0] ep = 4'd8;
      logic [3:0] pid = PID_OUT;
      logic ok = 1'b1;
      if (k == 0) begin
         a = 7'($urandom);
         if (a == DEV) a = 7'd6;
         pid = ($urandom_range(0, 1) != 0) ? PID_IN : PID_OUT;
      end else if (k == 1) begin
         ok = 1'b0;
         ep = ($urandom_range(0, 1) != 0) ? 4'd4 : 4'd8;
      end else if (k == 2) begin
         pid = PID_IN;
         ep = 4'd4;
      end else if (k == 3) begin
         ep = 4'($urandom);
         if (ep == 4'd4 || ep == 4'd8) ep = 4'd0;
      end else begin
         pid = ($urandom_range(0, 1) != 0) ? PID_DATA0 : PID_ACK;
      end
      send(pid, a, ep, rnd64(), ok);
      tick(3);
      check("flt_busy", 64'(busy), 64'd0);
      check("flt_ntx", 64'(tx_cnt - b_tx), 64'd0);
      check("flt_nmem", 64'((nw - b_w) + (nr - b_r)), 64'd0);
   endtask

   task automatic do_timeout(input logic [3:0] ep);
      int b_tx = tx_cnt, b_w = nw, b_r = nr;
      int n = 0;
      send(PID_OUT, DEV, ep, rnd64(), 1'b1);
      tick(250);
      check("to_busy_250", 64'(busy), 64'd1);
      while (busy && n < 20) begin
         tick();
         n++;
      end
      check("to_idle", 64'(busy), 64'd0);
      check("to_len", 64'((250 + n) >= 250 && (250 + n) <= 260), 64'd1);
      check("to_ntx", 64'(tx_cnt - b_tx), 64'd0);
      check("to_nmem", 64'((nw - b_w) + (nr - b_r)), 64'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] pool [0:3];
      int b_tx;
      pool[0] = 16'h0000; pool[1] = 16'hFFFF; pool[2] = 16'h1234; pool[3] = 16'h00A5;

      tick(3);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_tx_start", 64'(tx_start), 64'd0);
      check("rst_mem_re", 64'(mem_re), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_tx_pid", 64'(tx_pid), 64'd0);
      check("rst_tx_data", tx_data, 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", mem_wdata, 64'd0);
      rst_L = 1'b1;
      tick(2);

      do_addr(16'hFFFF, 1'b1);
      do_write(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      do_addr(16'h0040, 1'b1);
      do_write(64'h0123_4567_89AB_CDEF, 1'b1);
      do_read(0);
      do_addr(16'h1111, 1'b0);
      do_read(1);
      do_write(64'hDEAD_BEEF_0000_0001, 1'b0);
      do_write(64'hDEAD_BEEF_0000_0001, 1'b1);
      do_read(0);
      do_timeout(4'd4);
      do_filter(0);
      do_filter(2);

      b_tx = tx_cnt;
      send(PID_IN, DEV, 4'd8, rnd64(), 1'b1);
      wait_tx(b_tx, "rst_mid");
      tick(1);
      rst_L = 1'b0;
      #1;
      check("rstmid_busy", 64'(busy), 64'd0);
      check("rstmid_tx_start", 64'(tx_start), 64'd0);
      check("rstmid_tx_pid", 64'(tx_pid), 64'd0);
      check("rstmid_mem_addr", 64'(mem_addr), 64'd0);
      tick(2);
      rst_L = 1'b1;
      ref_addr = '0;
      b_tx = tx_cnt;
      tick(20);
      check("rstmid_no_tx", 64'(tx_cnt - b_tx), 64'd0);
      check("rstmid_idle", 64'(busy), 64'd0);
      do_read(0);

      for (int i = 0; i < 40; i++) begin
         int k = $urandom_range(0, 7);
         if (k <= 1) do_addr(pool[$urandom_range(0, 3)], $urandom_range(0, 4) != 0);
         else if (k <= 3) do_write(rnd64(), $urandom_range(0, 4) != 0);
         else if (k <= 5) do_read($urandom_range(0, 9) == 0 ? 2 : $urandom_range(0, 1));
         else if (k == 6) do_filter($urandom_range(0, 4));
         else if ($urandom_range(0, 2) == 0) do_timeout(($urandom_range(0, 1) != 0) ? 4'd4 : 4'd8);
         else do_filter($urandom_range(0, 4));
      end

      check("excl_strobes", 64'(n_excl), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
